// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: data/address widths and arbiter port indices.
package cpu_pkg;

   localparam int   WORD_W  = 32;
   localparam int   BADDR_W = 31;
   localparam logic PORT_F  = 1'b0;
   localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/rom_access_arbiter_rr_arb2.sv
// Two-way grant for fetch (F) and data (D) with round-robin or fixed F priority.
module rr_arb2
   import cpu_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic f_req,
   input  logic d_req,
   output logic f_gnt,
   output logic d_gnt
);

   logic last_grant;

   always_comb begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
      if (reset) begin
         if (f_req && d_req) begin
            // On a tie the port that did not win last time goes first
            if ((FIXED_PRIO != 0) || (last_grant == PORT_D)) begin
               f_gnt = 1'b1;
            end else begin
               d_gnt = 1'b1;
            end
         end else begin
            f_gnt = f_req;
            d_gnt = d_req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant <= PORT_D;
      end else if (f_gnt) begin
         last_grant <= PORT_F;
      end else if (d_gnt) begin
         last_grant <= PORT_D;
      end
   end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares the combinational ROM read port between fetch and data loads; one-cycle
// registered responses, alignment/range fault flags and a saturating conflict counter.
module rom_access_arbiter
   import cpu_pkg::*;
#(
   parameter int ROM_SIZE   = 256,
   parameter int FIXED_PRIO = 0,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 f_req,
   input  logic [BADDR_W-1:0]   f_addr,
   output logic                 f_gnt,
   output logic                 f_rvalid,
   output logic [WORD_W-1:0]    f_rdata,
   output logic                 f_err,
   input  logic                 d_req,
   input  logic [BADDR_W-1:0]   d_addr,
   output logic                 d_gnt,
   output logic                 d_rvalid,
   output logic [WORD_W-1:0]    d_rdata,
   output logic                 d_err,
   output logic [BADDR_W-1:0]   rom_addr,
   input  logic [WORD_W-1:0]    rom_data,
   output logic [CNT_W-1:0]     conflict_cnt
);

   localparam logic [BADDR_W-1:0] ROM_BYTES = BADDR_W'(4 * ROM_SIZE);

   function automatic logic is_fault(input logic [BADDR_W-1:0] a);
      return (a[1:0] != 2'b00) || (a >= ROM_BYTES);
   endfunction

   logic [BADDR_W-1:0] sel_addr;
   logic [BADDR_W-1:0] addr_hold_p1;
   logic               sel_vld;
   logic               fault;
   logic [WORD_W-1:0]  word;

   rr_arb2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_arb (
      .clk   (clk),
      .reset (reset),
      .f_req (f_req),
      .d_req (d_req),
      .f_gnt (f_gnt),
      .d_gnt (d_gnt)
   );

   always_comb begin
      sel_vld  = f_gnt | d_gnt;
      sel_addr = f_gnt ? f_addr : d_addr;
      fault    = is_fault(sel_addr);
      word     = fault ? '0 : rom_data;
      // Idle cycles keep presenting the last granted address
      rom_addr = sel_vld ? {sel_addr[BADDR_W-1:2], 2'b00} : addr_hold_p1;
   end

   always_ff @(posedge clk) begin
      if (sel_vld) begin
         addr_hold_p1 <= {sel_addr[BADDR_W-1:2], 2'b00};
      end
   end

   // Response stage: captured at the grant edge, valid for exactly one cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         f_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         f_err    <= 1'b0;
         d_err    <= 1'b0;
         f_rdata  <= '0;
         d_rdata  <= '0;
      end else begin
         f_rvalid <= f_gnt;
         d_rvalid <= d_gnt;
         if (f_gnt) begin
            f_rdata <= word;
            f_err   <= fault;
         end
         if (d_gnt) begin
            d_rdata <= word;
            d_err   <= fault;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         conflict_cnt <= '0;
      end else if (f_req && d_req && (conflict_cnt != {CNT_W{1'b1}})) begin
         conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares the single combinational read port of the instruction ROM between two requesters: instruction fetch (port F) and data-side loads that hit the ROM region (port D).
- Arbitrates per cycle, drives the ROM address and registers the returned word, so each response arrives exactly 1 cycle after its grant.
- Flags misaligned and out-of-range accesses and counts arbitration conflicts for profiling.
- Sits between the CPU fetch/memory stages and the ROM.

Parameters:
- ROM_SIZE, 256, number of 32-bit words in the ROM; valid byte addresses are 0 to 4*ROM_SIZE-1.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port F always wins a tie.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- f_req  in  1  fetch request; held with f_addr until f_gnt
- f_addr  in  31  fetch byte address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  fetch response valid (1 cycle after f_gnt)
- f_rdata  out  32  fetch response word
- f_err  out  1  fetch access fault, qualified by f_rvalid
- d_req  in  1  data request; held with d_addr until d_gnt
- d_addr  in  31  data byte address
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  data response valid
- d_rdata  out  32  data response word
- d_err  out  1  data access fault, qualified by d_rvalid
- rom_addr  out  31  address to ROM
- rom_data  in  32  combinational ROM read data
- conflict_cnt  out  CNT_W  saturating count of cycles with f_req and d_req both high

Behaviour:
- Reset (reset=0 at a clk edge):
  - f_rvalid, d_rvalid, f_err, d_err = 0; f_rdata, d_rdata = 0; conflict_cnt = 0.
  - last_grant pointer = D, so F wins the first tie.
  - f_gnt and d_gnt are forced 0 while reset is low.
  - Any response pending at the reset edge is dropped; no rvalid is issued for it.
- Grant (combinational, same cycle as the request):
  - Only one requester: that requester is granted.
  - Both requesting, FIXED_PRIO=0: grant the port not in last_grant.
  - Both requesting, FIXED_PRIO=1: grant F.
  - No request: no grant; rom_addr holds its last driven value, and nothing downstream depends on it.
- Pointer: last_grant updates at the edge to whichever port was granted. It is unchanged in idle cycles.
- ROM address: rom_addr = granted port's address with bits [1:0] forced to 0.
- Response, registered at the grant edge:
  - Granted port's rvalid = 1 next cycle; all other cycles rvalid = 0, so it is a single-cycle pulse per grant.
  - rdata = rom_data, or 0 on fault; err = fault.
  - Non-granted port's rdata/err hold their previous values.
- Fault: addr[1:0] != 0, or addr >= 4*ROM_SIZE (compare in 31 bits, no truncation).
- Throughput:
  - One grant per cycle total.
  - A continuously requesting port under round-robin waits at most 1 cycle.
  - Back-to-back grants to the same port are allowed when the other port is idle.
- Requester obligations:
  - Keep req and addr stable until gnt.
  - A new request may be presented in the cycle after gnt, i.e. the cycle when rvalid is high.
  - The arbiter does not check an addr that changes before gnt; the address sampled is the one present in the grant cycle.
- conflict_cnt: +1 per cycle with both req high and reset high; saturates at all-ones, no wrap.

Decomposition:
- Shared package (cpu_pkg): WORD_W=32, BADDR_W=31, port-index constants PORT_F=0 and PORT_D=1.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with a FIXED_PRIO override, containing the last_grant register.
- Response registers, fault check and counter stay in the top level.

Test Plan:
- Setup: ROM model preloaded with word0=0x20040054, word1=0x2005000c, word12=0x1485fff8.
- Reset then f_req=1, f_addr=0x0 -> f_gnt=1 same cycle; next cycle f_rvalid=1, f_rdata=0x20040054, f_err=0; d_rvalid=0.
- f_req and d_req both held high for 4 cycles, f_addr=0x4, d_addr=0x30, FIXED_PRIO=0 -> grants F,D,F,D; responses alternate 0x2005000c / 0x1485fff8; conflict_cnt=4.
- Same stimulus with FIXED_PRIO=1 -> F granted all 4 cycles; d_gnt stays 0; d_rvalid never asserts.
- d_addr=0x402 (misaligned) then d_addr=0x400 (out of range, ROM_SIZE=256) -> each gives d_rvalid=1, d_err=1, d_rdata=0; the following aligned access to 0x30 gives d_err=0.
- Grant F at cycle t, reset low at edge t+1 -> f_rvalid stays 0; all outputs at reset values; the first tie after reset is granted to F.
- Force CNT_W=4 and hold both requests for 20 cycles -> conflict_cnt reaches 15 and stays 15.
